// File: rtl/risc_multicycle_core.sv
// Multi-cycle accumulator-style RISC core: FETCH/EXEC/MEM/WRITE/HALT FSM sharing one
// request/acknowledge memory port for instruction fetch and data transfers.
module risc_multicycle_core #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12,
  parameter int NREGS    = 16
) (
  input  logic                clk,
  input  logic                reset,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_rdata,
  input  logic                mem_ack,
  output logic [ADDRSIZE-1:0] pc,
  output logic [4:0]          psr,
  output logic                halted,
  output logic                illegal
);

  localparam int RI = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_MEM   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_BRA = 4'd1;
  localparam logic [3:0] OP_LD  = 4'd2;
  localparam logic [3:0] OP_STR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_CMP = 4'd6;
  localparam logic [3:0] OP_SHF = 4'd7;
  localparam logic [3:0] OP_ROT = 4'd8;
  localparam logic [3:0] OP_HLT = 4'd9;

  logic [2:0]          state_reg;
  logic [WIDTH-1:0]    ir_reg;
  logic [ADDRSIZE-1:0] pc_reg;
  logic [4:0]          psr_reg;
  logic                halted_reg;
  logic                illegal_reg;
  logic                mem_req_reg;
  logic [ADDRSIZE-1:0] maddr_reg;
  logic [WIDTH-1:0]    mwdata_reg;
  logic                store_reg;
  logic [WIDTH:0]      result_reg;

  logic [WIDTH-1:0] rfile [NREGS];

  // Instruction fields
  logic [3:0]          opcode;
  logic                srctype;
  logic                dsttype;
  logic [3:0]          ccode;
  logic [ADDRSIZE-1:0] src_field;
  logic [ADDRSIZE-1:0] dst_field;
  logic [RI-1:0]       src_idx;
  logic [RI-1:0]       dst_idx;
  logic [WIDTH-1:0]    src_zext;

  assign opcode    = ir_reg[WIDTH-1:WIDTH-4];
  assign srctype   = ir_reg[WIDTH-5];
  assign dsttype   = ir_reg[WIDTH-6];
  assign ccode     = ir_reg[WIDTH-5:WIDTH-8];
  assign src_field = ir_reg[2*ADDRSIZE-1:ADDRSIZE];
  assign dst_field = ir_reg[ADDRSIZE-1:0];
  assign src_idx   = src_field[RI-1:0];
  assign dst_idx   = dst_field[RI-1:0];
  assign src_zext  = {{(WIDTH-ADDRSIZE){1'b0}}, src_field};

  // Operands and ALU
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic [2*WIDTH-1:0]  mul_full;
  logic [ADDRSIZE-1:0] count_s;
  logic                count_neg;
  logic [ADDRSIZE-1:0] mag;
  logic [31:0]         rot_amt;
  logic [WIDTH-1:0]    shifted;
  logic [WIDTH-1:0]    rotated;
  logic [WIDTH:0]      alu_res;
  logic [WIDTH-1:0]    str_val;

  assign op_a      = srctype ? src_zext : rfile[src_idx];
  assign op_b      = rfile[dst_idx];
  assign str_val   = op_a;
  assign mul_full  = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
  assign count_s   = op_a[ADDRSIZE-1:0];
  assign count_neg = count_s[ADDRSIZE-1];
  assign mag       = count_neg ? (-count_s) : count_s;
  assign rot_amt   = 32'(mag) % 32'(WIDTH);

  // Shifts past the datapath width fall out naturally as zero
  assign shifted = count_neg ? (op_b << mag) : (op_b >> mag);
  assign rotated = count_neg ? ((op_b << rot_amt) | (op_b >> (32'(WIDTH) - rot_amt)))
                             : ((op_b >> rot_amt) | (op_b << (32'(WIDTH) - rot_amt)));

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = {1'b0, op_a} + {1'b0, op_b};
      OP_MUL:  alu_res = mul_full[WIDTH:0];
      OP_CMP:  alu_res = {1'b0, ~op_a};
      OP_SHF:  alu_res = {1'b0, shifted};
      OP_ROT:  alu_res = {1'b0, rotated};
      default: alu_res = '0;
    endcase
  end

  function automatic logic [4:0] flags_of(input logic [WIDTH:0] r);
    flags_of = {r[WIDTH-1], (r[WIDTH-1:0] == '0), ^r[WIDTH-1:0], ~r[0], r[WIDTH]};
  endfunction

  logic br_take;
  always_comb begin
    br_take = 1'b0;
    case (ccode)
      4'd0:    br_take = 1'b1;
      4'd1:    br_take = psr_reg[0];
      4'd2:    br_take = psr_reg[1];
      4'd3:    br_take = psr_reg[2];
      4'd4:    br_take = psr_reg[3];
      4'd5:    br_take = psr_reg[4];
      default: br_take = 1'b0;
    endcase
  end

  logic is_alu;
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_MUL) || (opcode == OP_CMP) ||
                  (opcode == OP_SHF) || (opcode == OP_ROT);

  // Register-file write port: LD immediate in EXEC, LD memory on ack, ALU in WRITE
  logic             rf_we;
  logic [WIDTH-1:0] rf_wdata;
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = result_reg[WIDTH-1:0];
    case (state_reg)
      S_EXEC: if (opcode == OP_LD && srctype) begin
        rf_we    = 1'b1;
        rf_wdata = src_zext;
      end
      S_MEM: if (mem_req_reg && mem_ack && !store_reg) begin
        rf_we    = 1'b1;
        rf_wdata = mem_rdata;
      end
      S_WRITE: rf_we = 1'b1;
      default: rf_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rfile[i] <= '0;
    end else if (rf_we) begin
      rfile[dst_idx] <= rf_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      ir_reg      <= '0;
      pc_reg      <= '0;
      psr_reg     <= '0;
      halted_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      mem_req_reg <= 1'b0;
      maddr_reg   <= '0;
      mwdata_reg  <= '0;
      store_reg   <= 1'b0;
      result_reg  <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          // A fetch always follows at least one idle-request cycle after reset or a data ack
          if (!mem_req_reg) begin
            mem_req_reg <= 1'b1;
          end else if (mem_ack) begin
            ir_reg      <= mem_rdata;
            pc_reg      <= pc_reg + 1'b1;
            mem_req_reg <= 1'b0;
            state_reg   <= S_EXEC;
          end
        end
        S_EXEC: begin
          state_reg   <= S_FETCH;
          mem_req_reg <= 1'b1;
          case (opcode)
            OP_NOP: ;
            OP_BRA: if (br_take) pc_reg <= dst_field;
            OP_LD: begin
              if (srctype) begin
                psr_reg <= flags_of({1'b0, src_zext});
              end else begin
                state_reg <= S_MEM;
                maddr_reg <= src_field;
                store_reg <= 1'b0;
              end
            end
            OP_STR: begin
              state_reg  <= S_MEM;
              maddr_reg  <= dst_field;
              mwdata_reg <= str_val;
              store_reg  <= 1'b1;
              psr_reg    <= flags_of({1'b0, str_val});
            end
            OP_HLT: begin
              state_reg   <= S_HALT;
              halted_reg  <= 1'b1;
              mem_req_reg <= 1'b0;
            end
            default: begin
              if (is_alu && !dsttype) begin
                result_reg  <= alu_res;
                state_reg   <= S_WRITE;
                mem_req_reg <= 1'b0;
              end else begin
                illegal_reg <= 1'b1;
              end
            end
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            if (!store_reg) psr_reg <= flags_of({1'b0, mem_rdata});
            mem_req_reg <= 1'b0;
            state_reg   <= S_FETCH;
          end
        end
        S_WRITE: begin
          psr_reg     <= flags_of(result_reg);
          state_reg   <= S_FETCH;
          mem_req_reg <= 1'b1;
        end
        S_HALT: mem_req_reg <= 1'b0;
        default: begin
          state_reg   <= S_FETCH;
          mem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = (state_reg == S_MEM) && store_reg;
  assign mem_addr  = (state_reg == S_MEM) ? maddr_reg : pc_reg;
  assign mem_wdata = mwdata_reg;
  assign pc        = pc_reg;
  assign psr       = psr_reg;
  assign halted    = halted_reg;
  assign illegal   = illegal_reg;

  logic unused_bits;
  assign unused_bits = ^{ir_reg, mul_full};

endmodule
